// File: rtl/csla_design_pkg.sv
// Shared constants for the registered 4-bit carry-select adder.
//   ADD_W : operand width in bits
//   GRP_W : width of the lower ripple group; the upper group is ADD_W-GRP_W bits
//   OUT_W : width of the registered result {Cout, S3..S0}
package csla_design_pkg;
  localparam int unsigned ADD_W = 4;
  localparam int unsigned GRP_W = 2;
  localparam int unsigned OUT_W = ADD_W + 1;
endpackage

// File: rtl/csla_design_full_adder.sv
// Single-bit full adder, the building block of every ripple chain in the
// carry-select adder.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out, ab | cin(a ^ b)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;

  assign prop = a ^ b;
  assign sum  = prop ^ cin;
  assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/csla_design.sv
// Registered 4-bit carry-select adder with bit-level ports.
// The lower 2-bit group ripples from Cin. The upper 2-bit group is computed
// twice in parallel, once with preset carry Cin1 (path P0) and once with Cin2
// (path P1); the lower group's carry-out c2 picks one. With Cin1=0/Cin2=1 the
// result is A + B + Cin modulo 32. All outputs come straight from flops.
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset, clears all outputs
//   A0..A3, B0..B3 : operand bits, bit 0 is the LSB
//   Cin            : carry into bit 0
//   Cin1, Cin2     : preset carries for upper paths P0 and P1
//   S0..S3, Cout   : registered sum bits and carry out (1-cycle latency)
module csla_design
  import csla_design_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  input  logic Cin1,
  input  logic Cin2,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic Cout
);

  logic [ADD_W-1:0] a;
  logic [ADD_W-1:0] b;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};

  // Lower group: plain 2-stage ripple from Cin.
  logic [GRP_W-1:0] s_lo;
  logic             c1;
  logic             c2;

  full_adder u_fa_lo0 (.a(a[0]), .b(b[0]), .cin(Cin), .sum(s_lo[0]), .cout(c1));
  full_adder u_fa_lo1 (.a(a[1]), .b(b[1]), .cin(c1),  .sum(s_lo[1]), .cout(c2));

  // Upper group, speculative path P0 (carry-in Cin1).
  logic s2_p0, s3_p0, c3_p0, co_p0;

  full_adder u_fa_p0_2 (.a(a[GRP_W]),   .b(b[GRP_W]),   .cin(Cin1),  .sum(s2_p0), .cout(c3_p0));
  full_adder u_fa_p0_3 (.a(a[GRP_W+1]), .b(b[GRP_W+1]), .cin(c3_p0), .sum(s3_p0), .cout(co_p0));

  // Upper group, speculative path P1 (carry-in Cin2).
  logic s2_p1, s3_p1, c3_p1, co_p1;

  full_adder u_fa_p1_2 (.a(a[GRP_W]),   .b(b[GRP_W]),   .cin(Cin2),  .sum(s2_p1), .cout(c3_p1));
  full_adder u_fa_p1_3 (.a(a[GRP_W+1]), .b(b[GRP_W+1]), .cin(c3_p1), .sum(s3_p1), .cout(co_p1));

  // Result register {Cout, S3, S2, S1, S0}.
  logic [OUT_W-1:0] res_d;
  logic [OUT_W-1:0] res_q;

  always_comb begin
    res_d = '0;
    res_d[GRP_W-1:0] = s_lo;
    // c2 selects which speculative upper result is real; the preset carries
    // are used as given, so non-nominal Cin1/Cin2 propagate unchanged.
    if (c2) begin
      res_d[OUT_W-1:GRP_W] = {co_p1, s3_p1, s2_p1};
    end else begin
      res_d[OUT_W-1:GRP_W] = {co_p0, s3_p0, s2_p0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async clear drops any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign S0   = res_q[0];
  assign S1   = res_q[1];
  assign S2   = res_q[2];
  assign S3   = res_q[3];
  assign Cout = res_q[4];

endmodule

// File: tb/tb_csla_design.sv
// Self-checking bench for csla_design: directed vectors with hand-computed
// sums, asynchronous reset behaviour, and an exhaustive back-to-back stream
// of all A/B/Cin combinations with a reset inserted mid-stream.
module tb_csla_design;

  logic clk;
  logic rst_n;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic cin, cin1, cin2;
  logic s0, s1, s2, s3, cout;
  logic [4:0] res;

  int errs   = 0;
  int checks = 0;
  logic [4:0] last_exp;

  assign res = {cout, s3, s2, s1, s0};

  csla_design dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A0   (a_in[0]),
    .A1   (a_in[1]),
    .A2   (a_in[2]),
    .A3   (a_in[3]),
    .B0   (b_in[0]),
    .B1   (b_in[1]),
    .B2   (b_in[2]),
    .B3   (b_in[3]),
    .Cin  (cin),
    .Cin1 (cin1),
    .Cin2 (cin2),
    .S0   (s0),
    .S1   (s1),
    .S2   (s2),
    .S3   (s3),
    .Cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got {Cout,S}=%05b expected %05b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic c1, input logic c2);
    a_in = a;
    b_in = b;
    cin  = c;
    cin1 = c1;
    cin2 = c2;
  endtask

  // Called at a falling edge: drive, confirm the output still holds the
  // previous result (no combinational path), then check one edge later.
  task automatic do_vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic c1, input logic c2,
                        input logic [4:0] exp);
    apply(a, b, c, c1, c2);
    #1 check({tag, "_hold"}, res, last_exp);
    @(negedge clk);
    check(tag, res, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [4:0] prev_exp;
    bit         have_prev;
    bit         did_rst;
    int         i;

    rst_n = 1'b1;
    apply(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Asynchronous clear before any clock edge (first rising edge is at t=5).
    #1 rst_n = 1'b0;
    #1 check("rst_async", res, 5'b00000);

    // Reset holds through clock edges regardless of inputs.
    @(posedge clk);
    apply(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 check("rst_hold", res, 5'b00000);

    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = 5'b00000;

    do_vec("a1010_b0000",     4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b01010);
    do_vec("a1011_b1110",     4'b1011, 4'b1110, 1'b0, 1'b0, 1'b1, 5'b11001);
    do_vec("a1111_b1111",     4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 5'b11110);
    do_vec("a1111_b0000_c1",  4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 5'b10000);
    do_vec("p0_preset1",      4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 5'b00100);
    // c2=1 with Cin2=0: P1 is chosen and gets no carry, P0 would add one.
    do_vec("p1_preset0",      4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0, 5'b00000);
    do_vec("a0110_b0111_c1",  4'b0110, 4'b0111, 1'b1, 1'b0, 1'b1, 5'b01110);

    // Exhaustive stream, one vector per cycle, reset injected at vector 256.
    have_prev = 1'b0;
    did_rst   = 1'b0;
    prev_exp  = 5'b00000;
    i         = 0;
    while (i < 512) begin
      @(negedge clk);
      if (have_prev) check("stream", res, prev_exp);
      if (!rst_n) begin
        check("mid_rst_hold", res, 5'b00000);
        rst_n = 1'b1;
      end
      apply(i[7:4], i[3:0], i[8], 1'b0, 1'b1);
      if (i == 256 && !did_rst) begin
        #2 rst_n = 1'b0;
        #1 check("mid_rst_async", res, 5'b00000);
        did_rst   = 1'b1;
        have_prev = 1'b0;
      end else begin
        prev_exp  = 5'(i[7:4]) + 5'(i[3:0]) + 5'(i[8]);
        have_prev = 1'b1;
        i++;
      end
    end
    @(negedge clk);
    check("stream_last", res, prev_exp);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
